// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between an 8-bit synchronous FIFO and its consumer.
//   fifo_empty   : FIFO empty flag (FIFO -> consumer)
//   fifo_rd_en   : one-cycle read strobe (consumer -> FIFO)
//   fifo_rd_data : read data, valid the cycle after the rd_en edge (FIFO -> consumer)
// master = consumer side (fifo_uart_tx), slave = FIFO side.
`timescale 1ns/1ps
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;

  modport master (input fifo_empty, input fifo_rd_data, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_rd_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter. Pops one byte at a time from the FIFO read port
// and sends it as start bit, 8 data bits LSB first, optional even parity,
// then 1 or 2 stop bits.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high
//   fifo       : FIFO read port (master side: drives fifo_rd_en)
//   tx_enable  : 1 = new frames may start
//   tx         : serial line, idles high (registered)
//   busy       : 1 while a byte is being fetched or sent
//   frame_done : one-cycle pulse in the first IDLE cycle after the last stop bit
`timescale 1ns/1ps
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  fifo_uart_tx_if.master fifo,
  input  logic           tx_enable,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_data;

  logic          w_rd_en;
  logic          w_baud_last;
  logic [2:0]    w_next_bit;

  // Read strobe is combinational so the FIFO sees it in the same cycle the
  // decision is made; held low while reset is asserted.
  assign w_rd_en         = (r_state == IDLE) && tx_enable && !fifo.fifo_empty && !reset;
  assign fifo.fifo_rd_en = w_rd_en;
  assign w_baud_last     = (r_baud == BAUD_LAST);
  assign w_next_bit      = r_bit_cnt + 3'd1;
  assign busy            = (r_state != IDLE);

  // The bit counter is reused in STOP to count stop bits, so the baud
  // counter never needs to exceed one bit period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          tx        <= 1'b1;
          r_baud    <= '0;
          r_bit_cnt <= '0;
          if (w_rd_en) r_state <= FETCH;
        end
        FETCH: begin
          r_data  <= fifo.fifo_rd_data;
          tx      <= 1'b0;
          r_baud  <= '0;
          r_state <= START;
        end
        START: begin
          if (w_baud_last) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
            tx        <= r_data[0];
            r_state   <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx      <= ^r_data;
                r_state <= PARITY;
              end else begin
                tx      <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              r_bit_cnt <= w_next_bit;
              tx        <= r_data[w_next_bit];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        PARITY: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            tx      <= 1'b1;
            r_state <= STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit_cnt == STOP_LAST) begin
              r_bit_cnt  <= '0;
              frame_done <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_bit_cnt <= w_next_bit;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0;
  logic tx0, busy0, done0, tx1, busy1, done1;

  fifo_uart_tx_if if0();
  fifo_uart_tx_if if1();

  fifo_uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .fifo(if0), .tx_enable(en0),
    .tx(tx0), .busy(busy0), .frame_done(done0));

  fifo_uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .fifo(if1), .tx_enable(en1),
    .tx(tx1), .busy(busy1), .frame_done(done1));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFOs feeding each DUT: pop on rd_en, data valid next cycle.
  logic [7:0] fq0[$], fq1[$];
  logic [7:0] rd0 = '0, rd1 = '0;
  logic       emp0 = 1'b1, emp1 = 1'b1;
  assign if0.fifo_empty   = emp0;
  assign if0.fifo_rd_data = rd0;
  assign if1.fifo_empty   = emp1;
  assign if1.fifo_rd_data = rd1;

  always @(posedge clk) begin
    if (if0.fifo_rd_en && fq0.size() > 0) rd0 <= fq0.pop_front();
    if (if1.fifo_rd_en && fq1.size() > 0) rd1 <= fq1.pop_front();
    emp0 <= (fq0.size() == 0);
    emp1 <= (fq1.size() == 0);
  end

  // Which DUT the monitor watches, with its frame shape.
  logic sel = 1'b0;
  logic m_tx, m_busy, m_done, m_rd;
  int   m_par, m_stp;
  always_comb begin
    m_tx   = sel ? tx1   : tx0;
    m_busy = sel ? busy1 : busy0;
    m_done = sel ? done1 : done0;
    m_rd   = sel ? if1.fifo_rd_en : if0.fifo_rd_en;
    m_par  = sel ? 1 : 0;
    m_stp  = sel ? 2 : 1;
  end

  logic [7:0]  exp_q[$];
  int unsigned rd_stamps[$];
  int          rd_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    if (sel) fq1.push_back(b);
    else     fq0.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fq0.size() == 0 && fq1.size() == 0 && exp_q.size() == 0 && !m_busy && !m_rd) && n < maxc);
    chk("drain_within_budget", 32'(n < maxc), 1);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: on each read strobe pop the expected byte and check the whole
  // serial frame cycle by cycle, then the frame_done pulse.
  initial begin : monitor
    logic [7:0]  b;
    logic [11:0] bits;
    int          nb, bad;
    bit          skip, aborted;
    skip = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (reset || !m_rd) continue;
      rd_stamps.push_back(cyc);
      rd_cnt++;
      chk("rd_cycle_tx_idle", 32'(m_tx), 1);
      chk("read_has_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() == 0) continue;
      b    = exp_q.pop_front();
      nb   = 9 + m_par + m_stp;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
      if (m_par != 0) bits[9] = ($countones(b) % 2 == 1);
      aborted = 1'b0;
      @(negedge clk);
      if (reset) aborted = 1'b1;
      else begin
        chk("rd_en_one_cycle", 32'(m_rd), 0);
        chk("fetch_tx_high", 32'(m_tx), 1);
        chk("fetch_busy", 32'(m_busy), 1);
      end
      for (int k = 0; k < nb && !aborted; k++) begin
        bad = 0;
        for (int j = 0; j < 16 && !aborted; j++) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
          else if (m_tx !== bits[k] || m_done !== 1'b0 || m_busy !== 1'b1) bad++;
        end
        if (!aborted) chk($sformatf("byte%02h_framebit%0d", b, k), 32'(bad), 0);
      end
      if (!aborted) begin
        @(negedge clk);
        if (!reset) begin
          chk("frame_done_pulse", 32'(m_done), 1);
          chk("done_tx_idle", 32'(m_tx), 1);
          chk("done_busy_low", 32'(m_busy), 0);
        end
      end
      skip = 1'b1;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, bs, bad, n;
    int unsigned c0;

    // Reset values without any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_tx0", 32'(tx0), 1);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_rd_en0", 32'(if0.fifo_rd_en), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_tx1", 32'(tx1), 1);
    chk("rst_busy1", 32'(busy1), 0);
    repeat (3) step();
    reset = 1'b0;

    // Single byte 0xA5.
    step();
    en0  = 1'b1;
    base = rd_cnt;
    push(8'hA5);
    wait_drain(400);
    chk("a5_reads", 32'(rd_cnt - base), 1);

    // Back-to-back 0x00, 0xFF, 0x55.
    step();
    base = rd_cnt;
    bs   = rd_stamps.size();
    push(8'h00); push(8'hFF); push(8'h55);
    wait_drain(800);
    chk("b2b_reads", 32'(rd_cnt - base), 3);
    if (rd_stamps.size() >= bs + 3)
      for (int i = 1; i < 3; i++) chk("b2b_period", rd_stamps[bs+i] - rd_stamps[bs+i-1], 162);

    // Random bytes with random gaps (idle and back-to-back mixes).
    step();
    base = rd_cnt;
    for (int i = 0; i < 8; i++) begin
      push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 250)) step();
    end
    wait_drain(2000);
    chk("random_reads", 32'(rd_cnt - base), 8);

    // tx_enable low holds off reads; dropping it mid-frame finishes the frame.
    step();
    en0  = 1'b0;
    base = rd_cnt;
    push(8'h3A);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    chk("disabled_no_read", 32'(rd_cnt - base), 0);
    chk("disabled_tx_idle", 32'(bad), 0);
    step();
    en0 = 1'b1;
    repeat (60) step();
    chk("mid_data_busy", 32'(busy0), 1);
    push(8'hC6);
    en0 = 1'b0;
    repeat (250) step();
    chk("drop_enable_reads", 32'(rd_cnt - base), 1);
    chk("drop_enable_idle", 32'(busy0), 0);
    step();
    en0 = 1'b1;
    wait_drain(400);
    chk("reenable_reads", 32'(rd_cnt - base), 2);

    // Reset pulse in data bit 4: partial byte discarded, next byte sent.
    step();
    base = rd_cnt;
    bs   = rd_stamps.size();
    push(8'h3C); push(8'hC3);
    n = 0;
    while (rd_stamps.size() == bs && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_first_read_seen", 32'(rd_stamps.size() > bs), 1);
    if (rd_stamps.size() > bs) begin
      c0 = rd_stamps[bs];
      while (cyc < c0 + 2 + 16*5 + 8) @(negedge clk);
      chk("rst_precondition_busy", 32'(busy0), 1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_tx_immediate", 32'(tx0), 1);
      chk("rst_busy_immediate", 32'(busy0), 0);
      chk("rst_rd_en_low", 32'(if0.fifo_rd_en), 0);
      repeat (2) step();
      reset = 1'b0;
      wait_drain(400);
      chk("rst_total_reads", 32'(rd_cnt - base), 2);
    end

    // Parity + 2 stop bits on the second instance.
    step();
    en0  = 1'b0;
    sel  = 1'b1;
    en1  = 1'b1;
    base = rd_cnt;
    bs   = rd_stamps.size();
    push(8'h07);
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    wait_drain(1000);
    chk("par_reads", 32'(rd_cnt - base), 3);
    if (rd_stamps.size() >= bs + 3)
      for (int i = 1; i < 3; i++) chk("par_period", rd_stamps[bs+i] - rd_stamps[bs+i-1], 194);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
